// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit ADD/SUB built around one reused full-adder slice, LSB first.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E_WIDTH.
// Backpressure: start is taken only while ready=1; start during RUN is ignored.
module serial_adder_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;        // operand A shift register
   logic [WIDTH-1:0] r_b;        // operand B (already inverted for SUB)
   logic [WIDTH-1:0] r_acc;      // sum bits shift in from the MSB side
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_result;   // published result, 0 while running
   logic             r_cout;
   logic             r_overflow;
   logic             r_zero;

   logic             w_sum;
   logic             w_cout;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_next_acc;

   // The single full-adder slice plus the value the accumulator takes this cycle.
   // On the last bit the carry-in of the slice is the carry into the MSB, so
   // overflow is simply r_carry XOR w_cout at that edge.
   always_comb begin
      w_sum      = r_a[0] ^ r_b[0] ^ r_carry;
      w_cout     = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
      w_next_acc = {w_sum, r_acc[WIDTH-1:1]};
      w_last     = (r_cnt == CW'(WIDTH - 1));
      w_accept   = r_ready & start;
   end

   // Control FSM with all datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
         r_cout     <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
      end else if (w_accept) begin
         // Accept from IDLE or DONE: load operands, SUB is a + ~b + 1.
         r_state    <= S_RUN;
         r_a        <= a;
         r_b        <= op ? ~b : b;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_carry    <= op;
         r_ready    <= 1'b0;
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
         r_result   <= '0;
         r_cout     <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_acc   <= w_next_acc;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state    <= S_DONE;
                  r_busy     <= 1'b0;
                  r_ready    <= 1'b1;
                  r_done     <= 1'b1;
                  r_result   <= w_next_acc;
                  r_cout     <= w_cout;
                  r_overflow <= r_carry ^ w_cout;
                  r_zero     <= (w_next_acc == '0);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            S_IDLE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign ready    = r_ready;
   assign busy     = r_busy;
   assign done     = r_done;
   assign result   = r_result;
   assign cout     = r_cout;
   assign overflow = r_overflow;
   assign zero     = r_zero;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a scoreboard of expected results.
// Expected values come from a behavioural 33-bit add model.
// Outputs are sampled on the falling edge, inputs change on the falling edge.
module tb_serial_adder_ctrl;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
      logic         z;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;
   logic         zero;

   int   errors = 0;
   int   checks = 0;
   int   n_done = 0;
   int   cyc    = 0;
   exp_t sb_q[$];

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .ready(ready), .busy(busy), .done(done), .result(result),
      .cout(cout), .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (done === 1'b1) n_done = n_done + 1;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout sim did not finish");
      $fatal(1, "timeout");
   end

   function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t         m;
      logic [W-1:0] yy;
      logic [W:0]   f;
      yy    = o ? ~y : y;
      f     = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, o};
      m.res = f[W-1:0];
      m.co  = f[W];
      m.ov  = (x[W-1] == yy[W-1]) && (m.res[W-1] != x[W-1]);
      m.z   = (m.res == '0);
      return m;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one operation for a single cycle; ends on the falling edge after acceptance.
   task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      sb_q.push_back(model(o, x, y));
      @(negedge clk);
      start = 1'b0; a = '0; b = '0; op = 1'b0;
      chk("accept_busy", {63'd0, busy}, 64'd1);
      chk("accept_ready", {63'd0, ready}, 64'd0);
      chk("run_result_zero", {32'd0, result}, 64'd0);
   endtask

   // Wait (bounded) for done; compare against the scoreboard head.
   task automatic wait_done(input string tag, output int n, output int stamp);
      exp_t e;
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n = n + 1;
      end
      stamp = cyc;
      chk({tag, "_done_seen"}, {63'd0, done}, 64'd1);
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
         end else begin
            e = sb_q.pop_front();
            chk({tag, "_result"}, {32'd0, result}, {32'd0, e.res});
            chk({tag, "_cout"}, {63'd0, cout}, {63'd0, e.co});
            chk({tag, "_overflow"}, {63'd0, overflow}, {63'd0, e.ov});
            chk({tag, "_zero"}, {63'd0, zero}, {63'd0, e.z});
            chk({tag, "_ready_in_done"}, {63'd0, ready}, 64'd1);
         end
      end
   endtask

   // Full single operation: issue, wait for done with latency check, then verify pulse ends.
   task automatic run_op(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      int           n;
      int           s;
      logic [W-1:0] held;
      issue(o, x, y);
      wait_done(tag, n, s);
      chk({tag, "_latency"}, n, W);
      held = result;
      @(negedge clk);
      chk({tag, "_done_pulse_end"}, {63'd0, done}, 64'd0);
      chk({tag, "_idle_ready"}, {63'd0, ready}, 64'd1);
      chk({tag, "_result_hold"}, {32'd0, result}, {32'd0, held});
   endtask

   initial begin
      int   n;
      int   s1;
      int   s2;
      int   dc0;

      rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {63'd0, ready}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_result", {32'd0, result}, 64'd0);
      chk("rst_flags", {61'd0, cout, overflow, zero}, 64'd0);
      rst = 1'b0;

      // Basic arithmetic and flag boundaries
      run_op("add_5_3", 1'b0, 32'd5, 32'd3);
      chk("add_5_3_literal", {32'd0, result}, 64'h8);
      run_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h1);
      chk("add_ovf_literal", {31'd0, result, overflow}, {31'd0, 32'h8000_0000, 1'b1});
      run_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h1);
      chk("add_wrap_literal", {29'd0, result, cout, overflow, zero}, {29'd0, 32'h0, 3'b101});
      run_op("sub_5_5", 1'b1, 32'd5, 32'd5);
      chk("sub_5_5_literal", {29'd0, result, cout, overflow, zero}, {29'd0, 32'h0, 3'b101});
      run_op("sub_0_1", 1'b1, 32'd0, 32'd1);
      chk("sub_0_1_literal", {29'd0, result, cout, overflow, zero}, {29'd0, 32'hFFFF_FFFF, 3'b000});
      run_op("sub_ovf", 1'b1, 32'h8000_0000, 32'h1);
      chk("sub_ovf_literal", {31'd0, result, overflow}, {31'd0, 32'h7FFF_FFFF, 1'b1});
      run_op("add_mix", 1'b0, 32'hA5A5_1234, 32'h5A5A_EDCB);
      run_op("sub_mix", 1'b1, 32'h1234_5678, 32'h8765_4321);

      // start pulses during RUN are ignored
      dc0 = n_done;
      issue(1'b0, 32'd10, 32'd20);
      repeat (4) @(negedge clk);
      start = 1'b1; a = 32'd1; b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      start = 1'b1; a = 32'd1; b = 32'd1; op = 1'b1;
      @(negedge clk);
      start = 1'b0; op = 1'b0;
      wait_done("ignore_start", n, s1);
      chk("ignore_start_literal", {32'd0, result}, 64'd30);
      repeat (40) @(negedge clk);
      chk("ignore_start_one_done", n_done - dc0, 1);

      // reset in the middle of RUN discards the operation
      issue(1'b0, 32'd100, 32'd200);
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb_q.pop_back());
      chk("midrst_ready", {63'd0, ready}, 64'd1);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_result", {32'd0, result}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      dc0 = n_done;
      repeat (40) @(negedge clk);
      chk("midrst_no_done", n_done - dc0, 0);
      run_op("after_rst_7_8", 1'b0, 32'd7, 32'd8);
      chk("after_rst_literal", {32'd0, result}, 64'd15);

      // back-to-back with start held through DONE
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'd1; b = 32'd1;
      sb_q.push_back(model(1'b0, 32'd1, 32'd1));
      @(negedge clk);
      wait_done("b2b_first", n, s1);
      chk("b2b_first_literal", {32'd0, result}, 64'd2);
      op = 1'b1; a = 32'd9; b = 32'd4;
      sb_q.push_back(model(1'b1, 32'd9, 32'd4));
      @(negedge clk);
      chk("b2b_accept_busy", {63'd0, busy}, 64'd1);
      chk("b2b_done_not_extended", {63'd0, done}, 64'd0);
      chk("b2b_result_cleared", {32'd0, result}, 64'd0);
      start = 1'b0; op = 1'b0; a = '0; b = '0;
      wait_done("b2b_second", n, s2);
      chk("b2b_second_literal", {32'd0, result}, 64'd5);
      chk("b2b_spacing", s2 - s1, W + 1);
      @(negedge clk);
      chk("b2b_final_idle", {62'd0, ready, done}, 64'b10);
      chk("sb_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
